game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level sequencer for the snake datapath: owns game_status, the move-tick
//  schedule, the snake reinitialisation pulse and the death-flash timing.
//  Sits between the debounced keys / hit flags and the snake, apple and VGA
//  blocks; the snake block steps only on move_tick while game_status==PLAY.
// PARAMETERS
//  STEP_CYCLES   12_500_000  clocks between move ticks at base speed (0.25 s)
//  START_CYCLES  50_000_000  START-state hold before PLAY (1 s)
//  FLASH_CYCLES  12_500_000  clocks per die_flash half-period
//  FLASH_NUM     8           die_flash toggles in DIE before IDLE
//  STEP_MIN      3_125_000   floor on step period (SPEEDUP_EN only)
//  STEP_DEC      1_250_000   period reduction per 4 points (SPEEDUP_EN only)
// PORTS
//  CLK_50M      in   1   system clock, 50 MHz; only clock
//  RST          in   1   reset, synchronous, active-high
//  start_press  in   1   debounced start/restart key, 1-cycle pulse
//  hit_wall     in   1   snake hit wall flag (level)
//  hit_body     in   1   snake hit itself flag (level)
//  score_bcd    in   8   score, two BCD digits [7:4] tens, [3:0] ones
//  game_status  out  2   IDLE=00 START=01 PLAY=10 DIE=11
//  move_tick    out  1   1-cycle pulse: snake advances one cell
//  snake_rst    out  1   1-cycle pulse: snake/apple/score reinitialise
//  die_flash    out  1   1=draw snake, 0=blank (blink)
// BEHAVIOUR
//  Reset (RST high at posedge): state=IDLE, game_status=00, move_tick=0,
//   snake_rst=0, die_flash=1, all counters 0. Reset mid-game aborts to IDLE.
//  IDLE: die_flash=1, no ticks. start_press -> START next cycle.
//  START: snake_rst=1 in first START cycle only; start_cnt counts 0..START_CYCLES-1,
//   then -> PLAY; tick counter cleared on entry to PLAY. start_press ignored.
//  PLAY: tick_cnt counts 0..period-1; move_tick=1 exactly in the cycle tick_cnt
//   wraps (first tick STEP_CYCLES clocks after entering PLAY).
//   hit_wall|hit_body sampled each cycle -> DIE next cycle; a tick due in the
//   hit cycle is suppressed. start_press ignored.
//  DIE: move_tick=0; die_flash toggles every FLASH_CYCLES (first toggle to 0);
//   after FLASH_NUM toggles -> IDLE with die_flash=1. Hit flags ignored.
//  Outputs registered; game_status equals state encoding, no extra latency.
//  period = STEP_CYCLES unless SPEEDUP_EN; counters sized $clog2(max param)+1.
//  Hit flags stay high until snake_rst; controller does not clear them.
// CONFIGURATION
//  SPEEDUP_EN defined: level = tens*10+ones >> 2 (binary, from score_bcd);
//   period = max(STEP_MIN, STEP_CYCLES - level*STEP_DEC), recomputed
//   registered, applied at next tick_cnt wrap (never mid-interval).
//  SPEEDUP_EN undefined: period fixed at STEP_CYCLES; score_bcd unused.
// STRUCTURE
//  snake_pkg: game_status encodings (IDLE/START/PLAY/DIE), direction and
//   cell-type encodings shared with the snake and VGA blocks.
//  Sub-module tick_gen: programmable prescaler (clear, period in, pulse out),
//   reused for move_tick and the die_flash half-period timer.
// TESTING (STEP_CYCLES=4 START_CYCLES=6 FLASH_CYCLES=3 FLASH_NUM=4
//          STEP_MIN=2 STEP_DEC=1)
//  Reset then idle 20 clk -> status=00, die_flash=1, no move_tick/snake_rst.
//  start_press at t0 -> status=01 at t0+1, snake_rst high only t0+1,
//   status=10 after 6 START cycles; move_tick every 4th clk, 1 clk wide.
//  hit_body rises same cycle as due tick -> no tick, status=11 next clk.
//  DIE: die_flash 0,1,0,1 with 3-clk half-periods, then status=00, flash=1.
//  start_press during PLAY/DIE, and RST mid-PLAY -> ignored / immediate IDLE.
//  SPEEDUP_EN, score_bcd=8'h08 -> period 2 after next wrap; 8'h00 -> 4.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game datapath: game status, direction, cell type,
// plus constant helpers used for counter sizing and the speed-up step period.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DIE   = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_HEAD  = 2'b01,
    CELL_BODY  = 2'b10,
    CELL_APPLE = 2'b11
  } cell_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  // level = score >> 2; the period shrinks by dec per level but never below floor_p
  function automatic int unsigned speed_period(input logic [7:0] bcd,
                                               input int unsigned step,
                                               input int unsigned floor_p,
                                               input int unsigned dec);
    int unsigned level;
    int unsigned red;
    level = ((32'(bcd[7:4]) * 32'd10) + 32'(bcd[3:0])) >> 2;
    red   = level * dec;
    if (red + floor_p >= step) speed_period = floor_p;
    else                       speed_period = step - red;
  endfunction

endpackage

// File: rtl/game_ctrl_tick_gen.sv
// Programmable prescaler: counts 0..period_i-1 while enabled, tick_o is a
// combinational one-cycle pulse in the wrapping cycle; clr_i holds the count at 0.
module tick_gen #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && !clr_i && (cnt_q == period_i - W'(1));
    cnt_d  = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// Snake game sequencer: game status FSM, move-tick schedule, snake reinit pulse and
// death flash. Optional feature macro: SPEEDUP_EN (score-dependent step period).
module game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_CYCLES  = 12_500_000,
  parameter int unsigned START_CYCLES = 50_000_000,
  parameter int unsigned FLASH_CYCLES = 12_500_000,
  parameter int unsigned FLASH_NUM    = 8,
  parameter int unsigned STEP_MIN     = 3_125_000,
  parameter int unsigned STEP_DEC     = 1_250_000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       start_press,
  input  logic       hit_wall,
  input  logic       hit_body,
  input  logic [7:0] score_bcd,
  output logic [1:0] game_status,
  output logic       move_tick,
  output logic       snake_rst,
  output logic       die_flash
);

  localparam int unsigned CW = $clog2(max3(STEP_CYCLES, START_CYCLES, FLASH_CYCLES)) + 1;
  localparam int unsigned FW = $clog2(FLASH_NUM) + 1;

  game_state_e   state_q, state_d;
  logic [CW-1:0] start_cnt_q, start_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;
  logic          snake_rst_q, snake_rst_d;
  logic          move_tick_q, move_tick_d;
  logic [CW-1:0] period;
  logic          tick_wrap;
  logic          flash_wrap;
  logic          hit;

  assign hit = hit_wall | hit_body;

`ifdef SPEEDUP_EN
  logic [CW-1:0] target_q;
  logic [CW-1:0] period_q;

  // Target tracks the score every cycle; the live period only changes on a wrap
  // (or while the counter is idle) so an interval is never cut short.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      target_q <= CW'(STEP_CYCLES);
      period_q <= CW'(STEP_CYCLES);
    end else begin
      target_q <= CW'(speed_period(score_bcd, STEP_CYCLES, STEP_MIN, STEP_DEC));
      if (tick_wrap || state_q != ST_PLAY) period_q <= target_q;
    end
  end

  assign period = period_q;
`else
  logic speed_unused;
  assign speed_unused = (^score_bcd) ^ (STEP_MIN != STEP_DEC);
  assign period       = CW'(STEP_CYCLES);
`endif

  // A hit in the wrap cycle drops the enable, which suppresses that tick.
  tick_gen #(.W(CW)) u_move_tick (
    .clk_i    (CLK_50M),
    .rst_i    (RST),
    .clr_i    (state_q != ST_PLAY),
    .en_i     ((state_q == ST_PLAY) && !hit),
    .period_i (period),
    .tick_o   (tick_wrap)
  );

  tick_gen #(.W(CW)) u_flash_tick (
    .clk_i    (CLK_50M),
    .rst_i    (RST),
    .clr_i    (state_q != ST_DIE),
    .en_i     (state_q == ST_DIE),
    .period_i (CW'(FLASH_CYCLES)),
    .tick_o   (flash_wrap)
  );

  always_comb begin
    state_d     = state_q;
    start_cnt_d = '0;
    flash_cnt_d = '0;
    flash_d     = 1'b1;
    snake_rst_d = 1'b0;
    move_tick_d = tick_wrap;
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d     = ST_START;
          snake_rst_d = 1'b1;
        end
      end
      ST_START: begin
        if (start_cnt_q == CW'(START_CYCLES - 1)) state_d = ST_PLAY;
        else                                      start_cnt_d = start_cnt_q + CW'(1);
      end
      ST_PLAY: begin
        if (hit) state_d = ST_DIE;
      end
      ST_DIE: begin
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        // The final toggle coincides with the return to IDLE (flash forced on).
        if (flash_wrap) begin
          if (flash_cnt_q == FW'(FLASH_NUM - 1)) begin
            state_d     = ST_IDLE;
            flash_cnt_d = '0;
            flash_d     = 1'b1;
          end else begin
            flash_cnt_d = flash_cnt_q + FW'(1);
            flash_d     = !flash_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b1;
      snake_rst_q <= 1'b0;
      move_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      snake_rst_q <= snake_rst_d;
      move_tick_q <= move_tick_d;
    end
  end

  assign game_status = state_q;
  assign move_tick   = move_tick_q;
  assign snake_rst   = snake_rst_q;
  assign die_flash   = flash_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with shortened timing parameters.
module tb_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start_press;
  logic       hit_wall;
  logic       hit_body;
  logic [7:0] score_bcd;
  logic [1:0] game_status;
  logic       move_tick;
  logic       snake_rst;
  logic       die_flash;

  int unsigned n_tests;
  int unsigned n_fail;

  game_ctrl #(
    .STEP_CYCLES  (4),
    .START_CYCLES (6),
    .FLASH_CYCLES (3),
    .FLASH_NUM    (4),
    .STEP_MIN     (2),
    .STEP_DEC     (1)
  ) dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .start_press (start_press),
    .hit_wall    (hit_wall),
    .hit_body    (hit_body),
    .score_bcd   (score_bcd),
    .game_status (game_status),
    .move_tick   (move_tick),
    .snake_rst   (snake_rst),
    .die_flash   (die_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press start; returns in PLAY cycle 0 after checking the START phase.
  task automatic start_game();
    start_press = 1'b1;
    step();
    start_press = 1'b0;
    check("start_status", 32'(game_status), 32'h1);
    check("start_snake_rst", 32'(snake_rst), 32'h1);
    for (int i = 1; i < 6; i++) begin
      step();
      check("start_hold", 32'(game_status), 32'h1);
      check("start_rst_low", 32'(snake_rst), 32'h0);
    end
    step();
    check("play_entry", 32'(game_status), 32'h2);
    check("play_entry_tick", 32'(move_tick), 32'h0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start_press = 1'b0;
    hit_wall    = 1'b0;
    hit_body    = 1'b0;
    score_bcd   = 8'h00;
    step();
    step();
    rst = 1'b0;
    check("rst_status", 32'(game_status), 32'h0);
    check("rst_flash", 32'(die_flash), 32'h1);
    check("rst_tick", 32'(move_tick), 32'h0);
    check("rst_snake_rst", 32'(snake_rst), 32'h0);

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_status", 32'(game_status), 32'h0);
      check("idle_tick", 32'(move_tick), 32'h0);
      check("idle_snake_rst", 32'(snake_rst), 32'h0);
    end
    check("idle_flash", 32'(die_flash), 32'h1);

    // start_press one cycle into START must not restart or re-pulse
    start_press = 1'b1;
    step();
    check("start_status", 32'(game_status), 32'h1);
    check("start_snake_rst", 32'(snake_rst), 32'h1);
    step();
    start_press = 1'b0;
    check("start_ignore_press", 32'(snake_rst), 32'h0);
    for (int i = 2; i < 6; i++) begin
      step();
      check("start_hold", 32'(game_status), 32'h1);
    end
    step();
    check("play_entry", 32'(game_status), 32'h2);
    check("play_entry_tick", 32'(move_tick), 32'h0);

    // PLAY cycles 1..15: ticks at 4, 8, 12; press at cycle 2 ignored
    for (int i = 1; i <= 15; i++) begin
      if (i == 2) start_press = 1'b1;
      step();
      start_press = 1'b0;
      check("play_tick", 32'(move_tick), (i % 4 == 0) ? 32'h1 : 32'h0);
      check("play_status", 32'(game_status), 32'h2);
    end

    // hit in cycle 15 (wrap cycle): tick at 16 suppressed, DIE next
    hit_body = 1'b1;
    step();
    check("hit_tick_suppr", 32'(move_tick), 32'h0);
    check("hit_status", 32'(game_status), 32'h3);
    check("die_flash_d0", 32'(die_flash), 32'h1);

    for (int j = 1; j <= 12; j++) begin
      if (j == 5) start_press = 1'b1;
      step();
      start_press = 1'b0;
      check("die_flash", 32'(die_flash), ((j / 3) % 2 == 0) ? 32'h1 : 32'h0);
      check("die_status", 32'(game_status), (j < 12) ? 32'h3 : 32'h0);
      check("die_tick", 32'(move_tick), 32'h0);
    end
    hit_body = 1'b0;
    step();
    check("post_die_status", 32'(game_status), 32'h0);
    check("post_die_flash", 32'(die_flash), 32'h1);

    // reset during PLAY aborts straight to IDLE
    start_game();
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_status", 32'(game_status), 32'h0);
    check("midrst_tick", 32'(move_tick), 32'h0);
    check("midrst_flash", 32'(die_flash), 32'h1);
    check("midrst_snake_rst", 32'(snake_rst), 32'h0);
    step();
    check("midrst_stay_idle", 32'(game_status), 32'h0);

    // hit_wall path
    start_game();
    hit_wall = 1'b1;
    step();
    check("wall_status", 32'(game_status), 32'h3);
    hit_wall = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

`ifdef SPEEDUP_EN
    start_game();
    score_bcd = 8'h08;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("speed_fast_tick", 32'(move_tick),
            (i == 4 || i == 6 || i == 8 || i == 10) ? 32'h1 : 32'h0);
    end
    score_bcd = 8'h00;
    for (int i = 11; i <= 16; i++) begin
      step();
      check("speed_slow_tick", 32'(move_tick), (i == 12 || i == 16) ? 32'h1 : 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
